// File: rtl/lab4_pkg.sv
// -----------------------------------------------------------------------------
// lab4_pkg
// Shared definitions for the task dispatcher slice: operand width, default
// debounce length, dispatcher state encoding and the done-selection helper.
// -----------------------------------------------------------------------------
package lab4_pkg;

   // Operand width carried from the switches to the dispatched task
   localparam int DATA_W = 8;

   // 1 ms of stable key level at 50 MHz
   localparam int DB_CYCLES_DEFAULT = 50000;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2
   } state_e;

   // Completion of the task selected by mode; the other task's done is ignored
   function automatic logic sel_done(input logic mode, input logic done1, input logic done2);
      return mode ? done2 : done1;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Synchronizes the raw active-low pushbutton, optionally filters it, and emits a
// one-cycle press pulse on each released->pressed transition of the filtered
// level.
//
// Build option: DEBOUNCE_EN -- when defined, the level only changes after the
// synchronized input has disagreed with it for DB_CYCLES consecutive cycles.
// When undefined the level is the synchronizer output and no counter exists.
//
// Ports:
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset
//   key_n     in   raw pushbutton, active-low, asynchronous to clk
//   key_level out  debounced key level (1 = released)
//   press     out  one-cycle pulse on a 1->0 transition of key_level
// -----------------------------------------------------------------------------
module key_debounce
   import lab4_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic key_level,
   output logic press
);

   logic sync1_r;
   logic sync2_r;
   logic level_s;
   logic level_d_r;
   logic press_r;

   // Two-flop synchronizer; resets to the released level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
      end else begin
         sync1_r <= key_n;
         sync2_r <= sync1_r;
      end
   end

`ifdef DEBOUNCE_EN
   localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

   logic [CNT_W-1:0] cnt_r;
   logic             level_r;

   // Stability filter: any cycle where the input agrees with the level restarts the count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r   <= {CNT_W{1'b0}};
         level_r <= 1'b1;
      end else if (sync2_r != level_r) begin
         if (cnt_r == CNT_W'(DB_CYCLES - 1)) begin
            cnt_r   <= {CNT_W{1'b0}};
            level_r <= sync2_r;
         end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
            level_r <= level_r;
         end
      end else begin
         cnt_r   <= {CNT_W{1'b0}};
         level_r <= level_r;
      end
   end

   assign level_s = level_r;
`else
   assign level_s = sync2_r;
`endif

   // Falling-edge detector; the delayed copy resets released so a key held
   // across reset release still produces exactly one press
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_d_r <= 1'b1;
         press_r   <= 1'b0;
      end else begin
         level_d_r <= level_s;
         press_r   <= level_d_r & ~level_s;
      end
   end

   assign key_level = level_s;
   assign press     = press_r;

endmodule

// File: rtl/task_dispatch.sv
// -----------------------------------------------------------------------------
// task_dispatch
// Launches one of two tasks (bit counter / binary search) on a debounced press
// of the start key, latching the task select and operand at the press, and
// holds busy until the selected task reports done. Presses while busy are
// dropped.
//
// Build option: DEBOUNCE_EN (see key_debounce) adds a DB_CYCLES stability
// filter on the start key.
//
// Ports:
//   CLOCK_50  in   system clock
//   reset_n   in   asynchronous active-low reset
//   key_n     in   raw start pushbutton, active-low
//   sw_mode   in   task select: 0 = bit counter, 1 = binary search
//   sw_data   in   operand
//   t1_done   in   bit counter completion (level)
//   t2_done   in   binary search completion (level)
//   t1_start  out  one-cycle start pulse for the bit counter
//   t2_start  out  one-cycle start pulse for the binary search
//   op_mode   out  task select latched at the accepted press
//   op_data   out  operand latched at the accepted press
//   busy      out  high while a dispatched task is outstanding
// -----------------------------------------------------------------------------
module task_dispatch
   import lab4_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
   input  logic              CLOCK_50,
   input  logic              reset_n,
   input  logic              key_n,
   input  logic              sw_mode,
   input  logic [DATA_W-1:0] sw_data,
   input  logic              t1_done,
   input  logic              t2_done,
   output logic              t1_start,
   output logic              t2_start,
   output logic              op_mode,
   output logic [DATA_W-1:0] op_data,
   output logic              busy
);

   logic              key_level_s;
   logic              press_s;
   logic              done_s;
   state_e            state_r;
   logic              t1_start_r;
   logic              t2_start_r;
   logic              busy_r;
   logic              op_mode_r;
   logic [DATA_W-1:0] op_data_r;

   key_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_key_debounce (
      .clk       (CLOCK_50),
      .rst_n     (reset_n),
      .key_n     (key_n),
      .key_level (key_level_s),
      .press     (press_s)
   );

   assign done_s = sel_done(op_mode_r, t1_done, t2_done);

   // Dispatcher FSM with registered start/busy/operand outputs
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= ST_IDLE;
         t1_start_r <= 1'b0;
         t2_start_r <= 1'b0;
         busy_r     <= 1'b0;
         op_mode_r  <= 1'b0;
         op_data_r  <= {DATA_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (press_s) begin
                  state_r    <= ST_LAUNCH;
                  op_mode_r  <= sw_mode;
                  op_data_r  <= sw_data;
                  t1_start_r <= ~sw_mode;
                  t2_start_r <= sw_mode;
                  busy_r     <= 1'b1;
               end else begin
                  state_r    <= ST_IDLE;
                  t1_start_r <= 1'b0;
                  t2_start_r <= 1'b0;
                  busy_r     <= 1'b0;
               end
            end
            // done is deliberately not looked at here
            ST_LAUNCH: begin
               state_r    <= ST_WAIT;
               t1_start_r <= 1'b0;
               t2_start_r <= 1'b0;
               busy_r     <= 1'b1;
            end
            // Presses arriving here, including on the exit edge, are dropped
            ST_WAIT: begin
               t1_start_r <= 1'b0;
               t2_start_r <= 1'b0;
               if (done_s) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  state_r <= ST_WAIT;
                  busy_r  <= 1'b1;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               t1_start_r <= 1'b0;
               t2_start_r <= 1'b0;
               busy_r     <= 1'b0;
            end
         endcase
      end
   end

   assign t1_start = t1_start_r;
   assign t2_start = t2_start_r;
   assign busy     = busy_r;
   assign op_mode  = op_mode_r;
   assign op_data  = op_data_r;

endmodule

// File: tb/tb_task_dispatch.sv
// -----------------------------------------------------------------------------
// tb_task_dispatch
// Directed stimulus for task_dispatch. Each press that should launch a task
// pushes the expected start (which output, latched mode/data, arrival cycle)
// into a queue; an independent monitor pops and compares on every start pulse.
// Build with DEBOUNCE_EN to also exercise the key filter (DB_CYCLES = 4).
// -----------------------------------------------------------------------------
module tb_task_dispatch;

   localparam int DB = 4;
`ifdef DEBOUNCE_EN
   localparam int DB_EFF = DB;
`else
   localparam int DB_EFF = 0;
`endif
   // Edges from the first low sample of key_n to the start pulse
   localparam int LAT       = 3 + DB_EFF;
   localparam int PRESS_LEN = DB_EFF + 1;
   localparam int GAP       = 12 + DB_EFF;

   typedef struct {
      logic       mode;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   logic       CLOCK_50 = 1'b0;
   logic       reset_n  = 1'b0;
   logic       key_n    = 1'b1;
   logic       sw_mode  = 1'b0;
   logic [7:0] sw_data  = 8'h00;
   logic       t1_done  = 1'b0;
   logic       t2_done  = 1'b0;
   logic       t1_start;
   logic       t2_start;
   logic       op_mode;
   logic [7:0] op_data;
   logic       busy;

   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t exp_q[$];

   task_dispatch #(
      .DB_CYCLES (DB)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .reset_n  (reset_n),
      .key_n    (key_n),
      .sw_mode  (sw_mode),
      .sw_data  (sw_data),
      .t1_done  (t1_done),
      .t2_done  (t2_done),
      .t1_start (t1_start),
      .t2_start (t2_start),
      .op_mode  (op_mode),
      .op_data  (op_data),
      .busy     (busy)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every start pulse must match the oldest outstanding expectation
   always @(negedge CLOCK_50) begin
      if (reset_n && (t1_start || t2_start)) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_start", {30'd0, t2_start, t1_start}, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("start_cycle", cyc, e.cyc);
            chk("t1_start", {31'd0, t1_start}, {31'd0, ~e.mode});
            chk("t2_start", {31'd0, t2_start}, {31'd0, e.mode});
            chk("op_mode", {31'd0, op_mode}, {31'd0, e.mode});
            chk("op_data", {24'd0, op_data}, {24'd0, e.data});
            chk("busy_launch", {31'd0, busy}, 32'd1);
         end
      end
   end

   // Called at a negedge; key_n is first sampled low on the next posedge
   task automatic press(input int hold, input bit expect_start);
      exp_t e;
      key_n = 1'b0;
      if (expect_start) begin
         e.mode = sw_mode;
         e.data = sw_data;
         e.cyc  = cyc + 1 + LAT;
         exp_q.push_back(e);
      end
      repeat (hold) @(negedge CLOCK_50);
      key_n = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge CLOCK_50);
   endtask

   initial begin
      // Reset state
      idle(3);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_starts", {30'd0, t2_start, t1_start}, 32'd0);
      chk("rst_op", {23'd0, op_mode, op_data}, 32'd0);
      reset_n = 1'b1;
      idle(GAP);

      // Bit counter launch with operand 0xAC
      sw_mode = 1'b0;
      sw_data = 8'b1010_1100;
      press(PRESS_LEN, 1'b1);
      idle(LAT + 3);
      chk("t1_wait_busy", {31'd0, busy}, 32'd1);
      chk("t1_wait_data", {24'd0, op_data}, 32'h0000_00AC);
      t1_done = 1'b1;
      idle(1);
      chk("t1_done_busy", {31'd0, busy}, 32'd0);
      t1_done = 1'b0;
      idle(GAP);

      // Binary search launch; wrong done ignored
      sw_mode = 1'b1;
      sw_data = 8'd10;
      press(PRESS_LEN, 1'b1);
      idle(LAT + 3);
      chk("t2_wait_busy", {31'd0, busy}, 32'd1);
      t1_done = 1'b1;
      idle(2);
      chk("t2_other_done", {31'd0, busy}, 32'd1);
      t1_done = 1'b0;

      // Press and switch change while waiting: dropped, operand held
      sw_data = 8'h55;
      sw_mode = 1'b0;
      idle(GAP);
      press(PRESS_LEN, 1'b0);
      idle(GAP);
      chk("wait_op_data", {24'd0, op_data}, 32'h0000_000A);
      chk("wait_op_mode", {31'd0, op_mode}, 32'd1);
      chk("wait_busy", {31'd0, busy}, 32'd1);
      t2_done = 1'b1;
      idle(1);
      chk("t2_done_busy", {31'd0, busy}, 32'd0);
      t2_done = 1'b0;
      idle(GAP);

`ifdef DEBOUNCE_EN
      // Bouncing key: two-cycle toggles never satisfy the filter
      sw_mode = 1'b0;
      sw_data = 8'h21;
      for (int i = 0; i < 5; i++) begin
         key_n = 1'b0;
         idle(2);
         key_n = 1'b1;
         idle(2);
      end
      chk("bounce_busy", {31'd0, busy}, 32'd0);
      press(60, 1'b1);
      idle(10);
      t1_done = 1'b1;
      idle(1);
      t1_done = 1'b0;
      idle(GAP);
`endif

      // Long hold: one start only
      sw_mode = 1'b0;
      sw_data = 8'h3C;
      press(100, 1'b1);
      idle(GAP);
      chk("hold_busy", {31'd0, busy}, 32'd1);
      t1_done = 1'b1;
      idle(1);
      t1_done = 1'b0;
      idle(GAP);

      // Reset during WAIT: immediate reset values, task abandoned
      sw_mode = 1'b1;
      sw_data = 8'hE7;
      press(PRESS_LEN, 1'b1);
      idle(LAT + 3);
      chk("pre_rst_busy", {31'd0, busy}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_starts", {30'd0, t2_start, t1_start}, 32'd0);
      chk("arst_op", {23'd0, op_mode, op_data}, 32'd0);
      idle(1);
      reset_n = 1'b1;
      idle(GAP);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);

      chk("pending_starts", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/task_dispatch.md
TASK_DISPATCH -- requirements
Module: task_dispatch

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 50000, meaning the number of consecutive stable cycles required to accept a key level (1 ms at 50 MHz).
REQ-002 SHALL have port CLOCK_50  in  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port key_n  in  1  raw start pushbutton (KEY[3]); active-low; asynchronous to CLOCK_50.
REQ-005 SHALL have port sw_mode  in  1  task select (SW[9]): 0 = bit counter, 1 = binary search.
REQ-006 SHALL have port sw_data  in  8  operand (SW[7:0]).
REQ-007 SHALL have ports t1_done and t2_done  in  1 each  level-high completion from the bit counter and the binary search.
REQ-008 SHALL have ports t1_start and t2_start  out  1 each  single-cycle start pulses.
REQ-009 SHALL have port op_mode  out  1  task select latched at the accepted press.
REQ-010 SHALL have port op_data  out  8  operand latched at the accepted press.
REQ-011 SHALL have port busy  out  1  high while a dispatched task is outstanding.

Function
REQ-012 SHALL pass key_n through a 2-flop synchronizer before any use.
REQ-013 SHALL change the debounced key level only after the synchronized level has differed from it for DB_CYCLES consecutive cycles; any bounce restarts the count at 0.
REQ-014 SHALL generate a one-cycle press event on a 1->0 transition of the debounced level; a held key generates no further events, and a new event requires a release first.
REQ-015 SHALL implement an FSM with states IDLE, LAUNCH and WAIT.
- IDLE->LAUNCH on a press event; op_mode <= sw_mode and op_data <= sw_data on the same edge.
- LAUNCH->WAIT unconditionally after one cycle.
- WAIT->IDLE when the done of the selected task is high.
REQ-016 SHALL hold t1_start high (op_mode = 0) or t2_start high (op_mode = 1) for exactly the LAUNCH cycle; the other start output stays 0.
REQ-017 SHALL drive busy high in LAUNCH and WAIT and low in IDLE.
REQ-018 SHALL ignore done during LAUNCH and ignore the non-selected task's done in all states; simultaneous t1_done and t2_done resolve by op_mode.
REQ-019 SHALL drop, not queue, press events in LAUNCH or WAIT.
REQ-020 SHALL keep op_mode and op_data stable from the press until the next accepted press, unaffected by switch changes.
REQ-021 SHALL, when a press event coincides with a WAIT->IDLE exit, not accept that press.
REQ-022 SHALL, without DEBOUNCE_EN, assert the start pulse 3 rising edges after the first edge that samples key_n low (2 synchronizer edges + 1 event edge); with DEBOUNCE_EN, DB_CYCLES edges later.

Reset
REQ-023 SHALL, while reset_n = 0, force state IDLE, t1_start = t2_start = busy = 0, op_mode = 0, op_data = 8'h00, synchronizer flops and debounced level = 1 (released), and debounce counter = 0.
REQ-024 SHALL, on reset mid-task, abandon the task with no start re-issue; a key held low across reset release yields exactly one press event.

Configuration
REQ-025 SHALL, with DEBOUNCE_EN defined, implement the REQ-013 filter; without it, the debounced level equals the synchronizer output, DB_CYCLES is unused, and no counter is synthesized.

Structure
REQ-026 SHALL take the state enum typedef, the DATA_W = 8 constant and the default DB_CYCLES constant from shared package lab4_pkg.
REQ-027 SHALL place synchronizer, filter and press-edge detection in sub-module key_debounce (outputs: debounced level, press pulse).

Verification
REQ-028 SHALL cover: without DEBOUNCE_EN, reset, sw_mode = 0, sw_data = 8'b10101100, key_n low for 1 cycle -> t1_start high for exactly 1 cycle 3 edges later, op_data = 8'hAC, busy = 1; t1_done high -> busy = 0 on the next edge.
REQ-029 SHALL cover: sw_mode = 1, sw_data = 8'd10, press -> only t2_start pulses, op_mode = 1; t1_done high in WAIT -> busy stays 1; t2_done high -> IDLE.
REQ-030 SHALL cover: a second press and sw_data change to 8'h55 during WAIT -> no start pulse and op_data stays 8'h0A.
REQ-031 SHALL cover: DEBOUNCE_EN with DB_CYCLES = 4, key_n toggling every 2 cycles for 20 cycles then low steady -> exactly one start pulse, DB_CYCLES edges after the steady low begins.
REQ-032 SHALL cover: key_n held low for 100 cycles -> exactly one start pulse.
REQ-033 SHALL cover: reset_n low for 1 cycle during WAIT -> all outputs at reset values immediately (asynchronously), and no start pulse follows.
